// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locking arbiter feeding one 8N1 UART transmitter
// Requesters hand bytes over with valid/ready; a locked packet keeps the line until its last byte.

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 434,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       txd,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BW  = $clog2(CLKS_PER_BIT);
    localparam int LCW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr;
    logic             lock;
    logic [LCW-1:0]   lock_cnt;
    logic [BW-1:0]    baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;

    logic             sel_valid;
    logic [IDW-1:0]   sel_idx;
    logic [NUM_REQ-1:0] ready_vec;
    logic             accept;
    logic             bit_done;

    // Candidate selection: the lock owner alone, otherwise the first valid index after rr.
    always_comb begin
        int k;
        logic [IDW-1:0] cand;
        sel_valid = 1'b0;
        sel_idx   = '0;
        k         = 0;
        cand      = '0;
        if (lock) begin
            sel_valid = req_valid[grant_id];
            sel_idx   = grant_id;
        end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                k    = (int'(rr) + i) % NUM_REQ;
                cand = IDW'(k);
                if (!sel_valid && req_valid[cand]) begin
                    sel_valid = 1'b1;
                    sel_idx   = cand;
                end
            end
        end
    end

    assign accept   = (state == S_IDLE) && sel_valid && !reset;
    assign bit_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        ready_vec = '0;
        if (accept) begin
            ready_vec[sel_idx] = 1'b1;
        end
    end

    assign req_ready = ready_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
            grant_id <= '0;
            rr       <= IDW'(NUM_REQ - 1);
            lock     <= 1'b0;
            lock_cnt <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (accept) begin
                        shreg    <= req_data[{sel_idx, 3'b000} +: 8];
                        grant_id <= sel_idx;
                        rr       <= sel_idx;
                        lock     <= ~req_last[sel_idx];
                        lock_cnt <= '0;
                        txd      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_START;
                    end else if (lock && !req_valid[grant_id] && (LOCK_TIMEOUT != 0)) begin
                        // A stalled owner gives up the line after LOCK_TIMEOUT idle clocks.
                        if (lock_cnt == LCW'(LOCK_TIMEOUT - 1)) begin
                            lock     <= 1'b0;
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + LCW'(1);
                        end
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        txd      <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            txd   <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int CPB = 4;
    localparam int LT  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0] req_last;
    logic [NR-1:0] req_ready;
    logic          txd;
    logic          busy;
    logic [1:0]    grant_id;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .CLKS_PER_BIT (CPB),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .txd       (txd),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    logic [8:0]    rq [NR][$];
    logic [NR-1:0] fire = '0;
    int            cyc = 0;
    int            busy_cnt = 0;
    int            ready_cnt = 0;
    int            ready_busy_cnt = 0;
    int            tests = 0;
    int            fails = 0;
    logic [7:0]    rx_byte[$];
    int            rx_gid[$];
    int            rx_t0[$];
    int            acc_idx[$];
    int            acc_time[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rxb(input int i);
        return (i < rx_byte.size()) ? {24'h0, rx_byte[i]} : 32'hDEAD_BEEF;
    endfunction

    function automatic int rxg(input int i);
        return (i < rx_gid.size()) ? rx_gid[i] : -1;
    endfunction

    function automatic int rxt(input int i);
        return (i < rx_t0.size()) ? rx_t0[i] : -10000;
    endfunction

    function automatic int acci(input int i);
        return (i < acc_idx.size()) ? acc_idx[i] : -1;
    endfunction

    function automatic int acct(input int i);
        return (i < acc_time.size()) ? acc_time[i] : -10000;
    endfunction

    // Requester model: each queue head is presented; a handshake seen mid-cycle pops it.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                req_valid[i] = (rq[i].size() > 0);
                if (rq[i].size() > 0) begin
                    req_data[8*i +: 8] = rq[i][0][7:0];
                    req_last[i]        = rq[i][0][8];
                end
            end
        end
    end

    // Line monitor: decodes 8N1 frames at bit centres and logs accepts.
    initial begin
        int         rx_cnt;
        logic       rx_active;
        logic [7:0] sh;
        int         t0;
        int         gid;
        rx_active = 1'b0;
        rx_cnt    = 0;
        sh        = '0;
        t0        = 0;
        gid       = 0;
        forever begin
            @(negedge clk);
            cyc++;
            fire = reset ? '0 : (req_valid & req_ready);
            if (busy) busy_cnt++;
            if (req_ready != '0) begin
                ready_cnt++;
                if (busy) ready_busy_cnt++;
            end
            for (int i = 0; i < NR; i++) begin
                if (fire[i]) begin
                    acc_idx.push_back(i);
                    acc_time.push_back(cyc);
                end
            end
            if (reset) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (txd == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                    t0        = cyc;
                    gid       = int'(grant_id);
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == 2) begin
                    check("rx_start_bit", txd, 1'b0);
                end else if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) begin
                    sh = {txd, sh[7:1]};
                end else if (rx_cnt == 38) begin
                    check("rx_stop_bit", txd, 1'b1);
                    rx_byte.push_back(sh);
                    rx_gid.push_back(gid);
                    rx_t0.push_back(t0);
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic clear_logs();
        rx_byte.delete();
        rx_gid.delete();
        rx_t0.delete();
        acc_idx.delete();
        acc_time.delete();
        busy_cnt  = 0;
        ready_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NR; i++) rq[i].delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_frames(input int n, input string tag);
        int k;
        k = 0;
        while (rx_byte.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check(tag, rx_byte.size(), n);
    endtask

    task automatic wait_ready(input string tag, input logic [NR-1:0] exp);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 100);
        check(tag, req_ready, exp);
    endtask

    initial begin
        logic [7:0] pat;
        logic       exp_bit;
        int         b;
        logic [7:0] e2b [5];
        int         e2g [5];
        logic [7:0] e3b [4];
        int         e3g [4];

        // Reset state, with a request pending so ready gating is visible
        rq[2].push_back({1'b1, 8'hAA});
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, '0);
        check("rst_grant", grant_id, 2'd0);

        // 1: single frame waveform
        do_reset();
        rq[0].push_back({1'b1, 8'h55});
        pat = 8'h55;
        wait_ready("t1_ready", 4'b0001);
        for (int j = 0; j < 10 * CPB; j++) begin
            @(negedge clk);
            b = j / CPB;
            exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : pat[b-1];
            check("t1_txd", txd, exp_bit);
        end
        @(negedge clk);
        check("t1_idle_txd", txd, 1'b1);
        check("t1_idle_busy", busy, 1'b0);
        wait_frames(1, "t1_frames");
        check("t1_busy_clks", busy_cnt, 40);
        check("t1_ready_pulses", ready_cnt, 1);
        check("t1_byte", rxb(0), 8'h55);
        check("t1_grant", grant_id, 2'd0);

        // 2: round robin over four requesters, then back to 0
        do_reset();
        rq[0].push_back({1'b1, 8'hA0});
        rq[0].push_back({1'b1, 8'hB0});
        rq[1].push_back({1'b1, 8'hA1});
        rq[2].push_back({1'b1, 8'hA2});
        rq[3].push_back({1'b1, 8'hA3});
        e2b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0};
        e2g = '{0, 1, 2, 3, 0};
        wait_frames(5, "t2_frames");
        for (int i = 0; i < 5; i++) begin
            check("t2_byte", rxb(i), e2b[i]);
            check("t2_grant", rxg(i), e2g[i]);
        end

        // 3: packet lock keeps req2 out until req1's last byte
        do_reset();
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b0, 8'h22});
        rq[1].push_back({1'b1, 8'h33});
        rq[2].push_back({1'b1, 8'h99});
        e3b = '{8'h11, 8'h22, 8'h33, 8'h99};
        e3g = '{1, 1, 1, 2};
        wait_frames(4, "t3_frames");
        for (int i = 0; i < 4; i++) begin
            check("t3_byte", rxb(i), e3b[i]);
            check("t3_grant", rxg(i), e3g[i]);
        end

        // 4: stalled lock dropped after 16 idle clocks (accept 41+16 after the first)
        do_reset();
        rq[0].push_back({1'b0, 8'h01});
        rq[3].push_back({1'b1, 8'h3C});
        wait_frames(2, "t4_frames");
        check("t4_first_idx", acci(0), 0);
        check("t4_second_idx", acci(1), 3);
        check("t4_gap", acct(1) - acct(0), 57);
        check("t4_byte", rxb(1), 8'h3C);
        rq[1].push_back({1'b1, 8'h5E});
        wait_frames(3, "t4_unlocked_frames");
        check("t4_unlocked_byte", rxb(2), 8'h5E);

        // 5: reset during data bit 3 of 0xFF
        do_reset();
        rq[1].push_back({1'b1, 8'hFF});
        rq[1].push_back({1'b1, 8'h42});
        wait_ready("t5_ready", 4'b0010);
        repeat (18) @(posedge clk);
        #1;
        check("t5_pre_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("t5_rst_txd", txd, 1'b1);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_ready", req_ready, '0);
        rq[3].push_back({1'b1, 8'h77});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
        check("t5_rst_grant", grant_id, 2'd0);
        wait_frames(2, "t5_frames");
        check("t5_first_idx", acci(0), 1);
        check("t5_byte0", rxb(0), 8'h42);
        check("t5_byte1", rxb(1), 8'h77);
        check("t5_grant1", rxg(1), 3);

        // 6: back-to-back single-byte packets from one requester
        do_reset();
        rq[2].push_back({1'b1, 8'h5A});
        rq[2].push_back({1'b1, 8'hC3});
        wait_frames(2, "t6_frames");
        check("t6_spacing", rxt(1) - rxt(0), 41);
        check("t6_byte0", rxb(0), 8'h5A);
        check("t6_byte1", rxb(1), 8'hC3);
        check("t6_grant", rxg(1), 2);
        check("ready_during_busy", ready_busy_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
